blast_spreader: RTL and testbench

Sequential blast-propagation engine for the Bomber-Man playfield. On a bomb detonation it walks outward from the bomb tile in the four grid directions. It reads each tile's type from the wall map, emits one flame coordinate per burning tile, and issues clear-tile writes for breakable walls. It sits between the bomb controller (the writer of detonations) and the wall-matrix bitmap (the reader of its clear requests). The flame coordinates feed the flame sprite drawer.

---
 rtl/blast_pkg.sv | 51 +++++
 rtl/blast_coord_step.sv | 39 +++
 rtl/blast_spreader.sv | 202 ++++++++++++++++++++
 tb/tb_blast_spreader.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blast_pkg.sv
// Shared types, widths and defaults for the blast propagation engine.
package blast_pkg;

    localparam int unsigned GRID_W_DEF    = 19;
    localparam int unsigned GRID_H_DEF    = 13;
    localparam int unsigned MAX_RANGE_DEF = 4;

    localparam int unsigned COL_W    = 5;
    localparam int unsigned ROW_W    = 4;
    localparam int unsigned RANGE_W  = 3;
    localparam int unsigned COORD_SW = 6;

    typedef enum logic [1:0] {
        TILE_EMPTY     = 2'd0,
        TILE_BREAKABLE = 2'd1,
        TILE_SOLID     = 2'd2,
        TILE_RSVD      = 2'd3
    } tile_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    // NEXT_DIR has no encoding: it is resolved combinationally inside other states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CENTER = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_EVAL   = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } coord_t;

    // Clamp a requested blast range to the largest legal range.
    function automatic logic [RANGE_W-1:0] clamp_range(input logic [RANGE_W-1:0] req,
                                                       input int unsigned max_range);
        if (32'(req) > max_range) begin
            return RANGE_W'(max_range);
        end
        return req;
    endfunction

endpackage

// File: rtl/blast_coord_step.sv
// Combinational grid stepper: origin + step tiles in a direction, with bounds check.
module blast_coord_step
    import blast_pkg::*;
#(
    parameter int unsigned GRID_W = GRID_W_DEF,
    parameter int unsigned GRID_H = GRID_H_DEF
) (
    input  coord_t               origin,
    input  dir_t                 dir,
    input  logic [RANGE_W-1:0]   step,
    output coord_t               next,
    output logic                 out_of_grid
);

    localparam logic signed [COORD_SW-1:0] COL_LIM = COORD_SW'(GRID_W);
    localparam logic signed [COORD_SW-1:0] ROW_LIM = COORD_SW'(GRID_H);

    logic signed [COORD_SW-1:0] col_s;
    logic signed [COORD_SW-1:0] row_s;
    logic signed [COORD_SW-1:0] step_s;

    // Signed offset arithmetic; bounds are checked before truncating back to tile width.
    always_comb begin
        step_s = $signed(COORD_SW'(step));
        col_s  = $signed(COORD_SW'(origin.col));
        row_s  = $signed(COORD_SW'(origin.row));
        case (dir)
            DIR_N:   row_s = row_s - step_s;
            DIR_E:   col_s = col_s + step_s;
            DIR_S:   row_s = row_s + step_s;
            default: col_s = col_s - step_s;
        endcase
        out_of_grid = col_s[COORD_SW-1] | row_s[COORD_SW-1] |
                      (col_s >= COL_LIM) | (row_s >= ROW_LIM);
        next.col    = COL_W'(col_s);
        next.row    = ROW_W'(row_s);
    end

endmodule

// File: rtl/blast_spreader.sv
// Blast propagation engine: walks N/E/S/W from a detonated bomb, emitting flames and
// clear requests for breakable walls. Optional macro BLAST_PIERCE_EN lets a blast
// continue past a cleared breakable tile instead of stopping there.
module blast_spreader
    import blast_pkg::*;
#(
    parameter int unsigned GRID_W    = GRID_W_DEF,
    parameter int unsigned GRID_H    = GRID_H_DEF,
    parameter int unsigned MAX_RANGE = MAX_RANGE_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               detonate,
    input  logic [COL_W-1:0]   bomb_col,
    input  logic [ROW_W-1:0]   bomb_row,
    input  logic [RANGE_W-1:0] range,
    output logic               busy,
    output logic               done,
    output logic               tile_rd_en,
    output logic [COL_W-1:0]   tile_rd_col,
    output logic [ROW_W-1:0]   tile_rd_row,
    input  logic [1:0]         tile_rd_type,
    output logic               clr_valid,
    output logic [COL_W-1:0]   clr_col,
    output logic [ROW_W-1:0]   clr_row,
    input  logic               clr_ready,
    output logic               flame_valid,
    output logic [COL_W-1:0]   flame_col,
    output logic [ROW_W-1:0]   flame_row
);

    state_t             state_q, state_d;
    coord_t             bomb_q, bomb_d;
    logic [RANGE_W-1:0] range_q, range_d;
    logic [RANGE_W-1:0] step_q, step_d;
    dir_t               dir_q, dir_d;
    logic               flame_valid_q, flame_valid_d;
    coord_t             flame_q, flame_d;
    logic               clr_valid_q, clr_valid_d;
    coord_t             clr_q, clr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [RANGE_W-1:0] step_sel_c;
    coord_t             step_coord_c;
    logic               oob_c;
    logic               next_dir_c;
    logic               rd_en_c;

    // ISSUE looks one tile further out; EVAL/CLEAR revisit the tile just read.
    assign step_sel_c = (state_q == ST_ISSUE) ? RANGE_W'(step_q + 1'b1) : step_q;

    blast_coord_step #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_step (
        .origin      (bomb_q),
        .dir         (dir_q),
        .step        (step_sel_c),
        .next        (step_coord_c),
        .out_of_grid (oob_c)
    );

    // Next-state and output decode; direction advance is folded in as a branch.
    always_comb begin
        state_d       = state_q;
        bomb_d        = bomb_q;
        range_d       = range_q;
        step_d        = step_q;
        dir_d         = dir_q;
        flame_valid_d = 1'b0;
        flame_d       = flame_q;
        clr_valid_d   = clr_valid_q;
        clr_d         = clr_q;
        next_dir_c    = 1'b0;
        rd_en_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (detonate) begin
                    bomb_d        = '{col: bomb_col, row: bomb_row};
                    range_d       = clamp_range(range, MAX_RANGE);
                    step_d        = '0;
                    dir_d         = DIR_N;
                    flame_valid_d = 1'b1;
                    flame_d       = '{col: bomb_col, row: bomb_row};
                    state_d       = ST_CENTER;
                end
            end
            ST_CENTER: begin
                state_d = (range_q == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                step_d = step_sel_c;
                if (oob_c) begin
                    next_dir_c = 1'b1;
                end else begin
                    rd_en_c = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                case (tile_t'(tile_rd_type))
                    TILE_EMPTY: begin
                        flame_valid_d = 1'b1;
                        flame_d       = step_coord_c;
                        if (step_q == range_q) begin
                            next_dir_c = 1'b1;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end
                    TILE_BREAKABLE: begin
                        flame_valid_d = 1'b1;
                        flame_d       = step_coord_c;
                        clr_valid_d   = 1'b1;
                        clr_d         = step_coord_c;
                        state_d       = ST_CLEAR;
                    end
                    default: next_dir_c = 1'b1;
                endcase
            end
            ST_CLEAR: begin
                if (clr_ready) begin
                    clr_valid_d = 1'b0;
`ifdef BLAST_PIERCE_EN
                    if (step_q < range_q) begin
                        state_d = ST_ISSUE;
                    end else begin
                        next_dir_c = 1'b1;
                    end
`else
                    next_dir_c = 1'b1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (next_dir_c) begin
            step_d = '0;
            if (dir_q == DIR_W) begin
                state_d = ST_DONE;
            end else begin
                dir_d   = dir_t'(2'(dir_q + 2'd1));
                state_d = ST_ISSUE;
            end
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            bomb_q        <= '0;
            range_q       <= '0;
            step_q        <= '0;
            dir_q         <= DIR_N;
            flame_valid_q <= 1'b0;
            flame_q       <= '0;
            clr_valid_q   <= 1'b0;
            clr_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bomb_q        <= bomb_d;
            range_q       <= range_d;
            step_q        <= step_d;
            dir_q         <= dir_d;
            flame_valid_q <= flame_valid_d;
            flame_q       <= flame_d;
            clr_valid_q   <= clr_valid_d;
            clr_q         <= clr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Wall-map read must land in ISSUE so the type returns during EVAL.
    assign tile_rd_en  = rd_en_c;
    assign tile_rd_col = rd_en_c ? step_coord_c.col : '0;
    assign tile_rd_row = rd_en_c ? step_coord_c.row : '0;

    assign busy        = busy_q;
    assign done        = done_q;
    assign clr_valid   = clr_valid_q;
    assign clr_col     = clr_q.col;
    assign clr_row     = clr_q.row;
    assign flame_valid = flame_valid_q;
    assign flame_col   = flame_q.col;
    assign flame_row   = flame_q.row;

endmodule

// File: tb/tb_blast_spreader.sv
// Scoreboard bench for blast_spreader: a direction-walking reference model queues the
// expected flames and clears; a monitor pops and compares them as the DUT emits them.
module tb_blast_spreader;

    localparam int GW = 19;
    localparam int GH = 13;
    localparam int MR = 4;
`ifdef BLAST_PIERCE_EN
    localparam bit PIERCE = 1'b1;
`else
    localparam bit PIERCE = 1'b0;
`endif

    logic       clk;
    logic       resetN;
    logic       detonate;
    logic [4:0] bomb_col;
    logic [3:0] bomb_row;
    logic [2:0] range;
    logic       busy;
    logic       done;
    logic       tile_rd_en;
    logic [4:0] tile_rd_col;
    logic [3:0] tile_rd_row;
    logic [1:0] tile_rd_type;
    logic       clr_valid;
    logic [4:0] clr_col;
    logic [3:0] clr_row;
    logic       clr_ready;
    logic       flame_valid;
    logic [4:0] flame_col;
    logic [3:0] flame_row;

    blast_spreader #(.GRID_W(GW), .GRID_H(GH), .MAX_RANGE(MR)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .detonate     (detonate),
        .bomb_col     (bomb_col),
        .bomb_row     (bomb_row),
        .range        (range),
        .busy         (busy),
        .done         (done),
        .tile_rd_en   (tile_rd_en),
        .tile_rd_col  (tile_rd_col),
        .tile_rd_row  (tile_rd_row),
        .tile_rd_type (tile_rd_type),
        .clr_valid    (clr_valid),
        .clr_col      (clr_col),
        .clr_row      (clr_row),
        .clr_ready    (clr_ready),
        .flame_valid  (flame_valid),
        .flame_col    (flame_col),
        .flame_row    (flame_row)
    );

    logic [1:0] tmap [GH][GW];
    int exp_flames[$];
    int exp_clrs[$];
    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int reads_seen = 0;
    int done_seen  = 0;
    int rmode      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int enc(input logic [4:0] c, input logic [3:0] r);
        return int'(c) * 100 + int'(r);
    endfunction

    task automatic clear_map();
        for (int r = 0; r < GH; r++)
            for (int c = 0; c < GW; c++)
                tmap[r][c] = 2'd0;
    endtask

    task automatic random_map();
        int v;
        for (int r = 0; r < GH; r++)
            for (int c = 0; c < GW; c++) begin
                v = $urandom_range(0, 8);
                tmap[r][c] = (v < 5) ? 2'd0 : (v < 7) ? 2'd1 : 2'(v - 5);
            end
    endtask

    // Reference: walk each direction tile by tile from the spec rules.
    task automatic model_push(input int bc, input int br, input int rng,
                              output int reads, output int lat);
        int dc[4] = '{0, 1, 0, -1};
        int dr[4] = '{-1, 0, 1, 0};
        int eff, c, r;
        eff = (rng > MR) ? MR : rng;
        exp_flames.push_back(bc * 100 + br);
        lat   = 1;
        reads = 0;
        if (eff > 0) begin
            for (int d = 0; d < 4; d++) begin
                for (int s = 1; s <= eff; s++) begin
                    c = bc + dc[d] * s;
                    r = br + dr[d] * s;
                    if (c < 0 || c >= GW || r < 0 || r >= GH) begin
                        lat += 1;
                        break;
                    end
                    lat   += 2;
                    reads += 1;
                    if (tmap[r][c] == 2'd0) begin
                        exp_flames.push_back(c * 100 + r);
                    end else if (tmap[r][c] == 2'd1) begin
                        exp_flames.push_back(c * 100 + r);
                        exp_clrs.push_back(c * 100 + r);
                        lat += 1;
                        if (!PIERCE) break;
                    end else begin
                        break;
                    end
                end
            end
        end
        lat += 1;
    endtask

    // Wall-map model: the type for an address read in one cycle appears in the next.
    initial begin : rd_model
        logic en;
        int c, r;
        tile_rd_type = 2'd0;
        forever begin
            @(negedge clk);
            en = tile_rd_en;
            c  = int'(tile_rd_col);
            r  = int'(tile_rd_row);
            @(posedge clk);
            #1;
            if (en && c < GW && r < GH) tile_rd_type = tmap[r][c];
            else tile_rd_type = 2'($urandom);
        end
    end

    // clr_ready driver: 0 always, 1 random, 2 low for three valid cycles, 3 never.
    initial begin : rdy_drv
        int cnt;
        cnt = 0;
        clr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt = clr_valid ? cnt + 1 : 0;
            case (rmode)
                0:       clr_ready = 1'b1;
                1:       clr_ready = 1'($urandom);
                2:       clr_ready = (cnt >= 4);
                default: clr_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops expected flames/clears as the DUT presents them.
    initial begin : mon
        int e;
        int prev_clr;
        bit clr_pend;
        clr_pend = 1'b0;
        prev_clr = 0;
        forever begin
            @(negedge clk);
            if (flame_valid) begin
                if (exp_flames.size() == 0) chk("flame_extra", enc(flame_col, flame_row), -1);
                else begin
                    e = exp_flames.pop_front();
                    chk("flame", enc(flame_col, flame_row), e);
                end
            end
            if (clr_valid) begin
                if (clr_pend) chk("clr_stable", enc(clr_col, clr_row), prev_clr);
                if (clr_ready) begin
                    if (exp_clrs.size() == 0) chk("clr_extra", enc(clr_col, clr_row), -1);
                    else begin
                        e = exp_clrs.pop_front();
                        chk("clr", enc(clr_col, clr_row), e);
                    end
                    if (int'(clr_col) < GW && int'(clr_row) < GH) tmap[clr_row][clr_col] = 2'd0;
                    clr_pend = 1'b0;
                end else begin
                    clr_pend = 1'b1;
                    prev_clr = enc(clr_col, clr_row);
                end
            end else begin
                clr_pend = 1'b0;
            end
            if (tile_rd_en) begin
                reads_seen++;
                chk("rd_in_grid", int'(int'(tile_rd_col) < GW && int'(tile_rd_row) < GH), 1);
            end
            if (done) done_seen++;
        end
    end

    task automatic run_blast(input int bc, input int br, input int rng, input int mode,
                             input int extra, input bit chk_lat, input bit poke);
        int reads, lat, n0, rd0, dn0;
        bit got;
        model_push(bc, br, rng, reads, lat);
        rd0   = reads_seen;
        dn0   = done_seen;
        rmode = mode;
        @(posedge clk);
        #1;
        detonate = 1'b1;
        bomb_col = 5'(bc);
        bomb_row = 4'(br);
        range    = 3'(rng);
        n0       = cyc;
        @(negedge clk);
        chk("busy_idle", busy, 0);
        @(posedge clk);
        #1;
        detonate = 1'b0;
        @(negedge clk);
        chk("busy_start", busy, 1);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (poke && cyc == n0 + 4) begin
                detonate = 1'b1;
                bomb_col = 5'd1;
                bomb_row = 4'd1;
                range    = 3'd2;
            end
            if (poke && cyc == n0 + 5) detonate = 1'b0;
            @(negedge clk);
        end
        detonate = 1'b0;
        if (!got) begin
            chk("done_timeout", 0, 1);
        end else begin
            if (chk_lat) chk("done_latency", cyc - n0, lat + extra);
            chk("busy_at_done", busy, 1);
        end
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_width", done, 0);
        repeat (poke ? 12 : 2) @(negedge clk);
        chk("flames_pending", exp_flames.size(), 0);
        chk("clrs_pending", exp_clrs.size(), 0);
        chk("read_count", reads_seen - rd0, reads);
        chk("done_count", done_seen - dn0, 1);
        exp_flames.delete();
        exp_clrs.delete();
    endtask

    task automatic reset_mid_clear();
        int reads, lat, dn0;
        bit got;
        clear_map();
        tmap[3][5] = 2'd1;
        model_push(5, 4, 2, reads, lat);
        rmode = 3;
        dn0   = done_seen;
        @(posedge clk);
        #1;
        detonate = 1'b1;
        bomb_col = 5'd5;
        bomb_row = 4'd4;
        range    = 3'd2;
        @(posedge clk);
        #1;
        detonate = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (clr_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("clr_reached", got, 1);
        resetN = 1'b0;
        @(negedge clk);
        chk("rst_clr_valid", clr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flame_valid", flame_valid, 0);
        chk("rst_rd_en", tile_rd_en, 0);
        chk("rst_done", done, 0);
        resetN = 1'b1;
        exp_flames.delete();
        exp_clrs.delete();
        repeat (4) @(negedge clk);
        chk("no_done_after_reset", done_seen - dn0, 0);
        run_blast(5, 4, 2, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        int bc, br, rng, mode;
        resetN   = 1'b0;
        detonate = 1'b0;
        bomb_col = '0;
        bomb_row = '0;
        range    = '0;
        clear_map();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_flame_valid", flame_valid, 0);
        chk("reset_clr_valid", clr_valid, 0);
        chk("reset_rd_en", tile_rd_en, 0);
        chk("reset_flame_xy", enc(flame_col, flame_row), 0);
        chk("reset_clr_xy", enc(clr_col, clr_row), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        run_blast(5, 4, 1, 0, 0, 1'b1, 1'b0);
        run_blast(0, 0, 2, 0, 0, 1'b1, 1'b0);
        clear_map();
        tmap[4][7] = 2'd1;
        tmap[2][5] = 2'd2;
        run_blast(5, 4, 3, 2, 3, 1'b1, 1'b0);
        clear_map();
        run_blast(9, 6, 7, 0, 0, 1'b1, 1'b1);
        run_blast(3, 3, 0, 0, 0, 1'b1, 1'b0);
        reset_mid_clear();

        for (int i = 0; i < 30; i++) begin
            random_map();
            bc   = $urandom_range(0, GW - 1);
            br   = $urandom_range(0, GH - 1);
            rng  = $urandom_range(0, 7);
            mode = i % 2;
            run_blast(bc, br, rng, mode, 0, mode == 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
